// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST burst host.
//   burst_state_e    : host FSM states
//   MBIST_FIFO_DEPTH : default beat-buffer depth
//   BEAT_CNT_WD      : width of burst length / beat counters
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        DRAIN    = 2'd3
    } burst_state_e;

    localparam int MBIST_FIFO_DEPTH = 4;
    localparam int BEAT_CNT_WD      = 10;

endpackage

// File: rtl/mbist_burst_fifo.sv
// Beat buffer for the MBIST burst host, shared by write and read bursts.
// Ports:
//   clk_i, rst_n        : clock, async active-low reset
//   push_i, din_i       : write side (ignored when full unless popping too)
//   pop_i, dout_o       : read side; dout_o is the head, 0 when empty
//   flush_i             : drop all entries (wins over push/pop)
//   full_o, empty_o     : status
//   count_o             : occupancy, $clog2(DEPTH)+1 bits
module mbist_burst_fifo
    import mbist_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = MBIST_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rp_q];

    // A push into a full buffer is fine when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/mbist_burst_host.sv
// MBIST burst host: accepts one burst command at a time, streams write beats
// from wdat_* to the mbist_wb burst port, or read beats from it to rdat_*,
// through a shared beat buffer.
// Ports:
//   wb_clk_i, rst_n              : clock, async active-low reset
//   cmd_*                        : command handshake and fields (we/adr/cs/sel/bl)
//   wdat_val_i/wdat_i/wdat_rdy_o : write-beat stream in
//   rdat_val_o/rdat_o/rdat_rdy_i : read-beat stream out
//   wb_*_o / wb_*_i              : burst request port and responses
//   done_o / err_o               : one-cycle pulses, burst completed / aborted
// Build option: MBIST_BURST_TIMEOUT_EN adds an 8-bit no-ack watchdog that
// aborts a stalled burst after 255 cycles; without it a burst waits forever.
module mbist_burst_host
    import mbist_pkg::*;
#(
    parameter int BIST_NO_SRAM  = 4,
    parameter int BIST_ADDR_WD  = 9,
    parameter int BIST_DATA_WD  = 32,
    parameter int FIFO_DEPTH    = MBIST_FIFO_DEPTH,
    localparam int CS_WD        = (BIST_NO_SRAM + 1) / 2,
    localparam int CNT_WD       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    input  logic                      cmd_val_i,
    output logic                      cmd_rdy_o,
    input  logic                      cmd_we_i,
    input  logic [BIST_ADDR_WD-1:0]   cmd_adr_i,
    input  logic [CS_WD-1:0]          cmd_cs_i,
    input  logic [BIST_DATA_WD/8-1:0] cmd_sel_i,
    input  logic [9:0]                cmd_bl_i,
    input  logic                      wdat_val_i,
    input  logic [BIST_DATA_WD-1:0]   wdat_i,
    output logic                      wdat_rdy_o,
    output logic                      rdat_val_o,
    output logic [BIST_DATA_WD-1:0]   rdat_o,
    input  logic                      rdat_rdy_i,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [BIST_ADDR_WD-1:0]   wb_adr_o,
    output logic [CS_WD-1:0]          wb_cs_o,
    output logic [BIST_DATA_WD/8-1:0] wb_sel_o,
    output logic [9:0]                wb_bl_o,
    output logic [BIST_DATA_WD-1:0]   wb_dat_o,
    output logic                      wb_bry_o,
    input  logic [BIST_DATA_WD-1:0]   wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_lack_i,
    input  logic                      wb_err_i,
    output logic                      done_o,
    output logic                      err_o
);

    burst_state_e state_q, state_d;
    logic                      rdy_q, stb_q, stb_d, we_q, we_d, done_q, done_d, err_q, err_d;
    logic [BIST_ADDR_WD-1:0]   adr_q, adr_d;
    logic [CS_WD-1:0]          cs_q, cs_d;
    logic [BIST_DATA_WD/8-1:0] sel_q, sel_d;
    logic [BEAT_CNT_WD-1:0]    bl_q, bl_d, beat_q, beat_d, pcnt_q, pcnt_d;

    logic                    f_push, f_pop, f_flush, f_full, f_empty;
    logic [BIST_DATA_WD-1:0] f_din, f_dout;
    logic [CNT_WD-1:0]       f_count;

    logic in_wr, in_rd, in_dr, wdog_hit, abort, wr_bry, rd_bry;

    assign in_wr = (state_q == WR_BURST);
    assign in_rd = (state_q == RD_BURST);
    assign in_dr = (state_q == DRAIN);
    assign abort = (state_q != IDLE) && (wb_err_i || wdog_hit);

`ifdef MBIST_BURST_TIMEOUT_EN
    logic [7:0] wdog_q;
    assign wdog_hit = (in_wr || in_rd) && (wdog_q == 8'hFF);
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)                          wdog_q <= '0;
        else if (!(in_wr || in_rd) || wb_ack_i) wdog_q <= '0;
        else if (!wdog_hit)                  wdog_q <= wdog_q + 8'd1;
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Datapath around the shared buffer.
    assign wdat_rdy_o = in_wr && !f_full && (pcnt_q < bl_q);
    assign f_push  = in_wr ? (wdat_val_i && wdat_rdy_o) : (in_rd && wb_ack_i);
    assign f_din   = in_wr ? wdat_i : wb_dat_i;
    assign rdat_val_o = (in_rd || in_dr) && !f_empty;
    assign rdat_o  = (in_rd || in_dr) ? f_dout : '0;
    assign f_pop   = in_wr ? wb_ack_i : (rdat_val_o && rdat_rdy_i);
    assign f_flush = abort;
    assign wb_dat_o = in_wr ? f_dout : '0;

    // Write: advertise a beat only if one is still buffered after this
    // cycle's ack pops the head. Read: keep room for the in-flight ack plus
    // one more, and never request beyond the burst length.
    assign wr_bry   = (f_count > CNT_WD'(wb_ack_i));
    assign rd_bry   = (f_count <= CNT_WD'(FIFO_DEPTH - 2)) && ((beat_q + BEAT_CNT_WD'(wb_ack_i)) < bl_q);
    assign wb_bry_o = !abort && ((in_wr && wr_bry) || (in_rd && rd_bry));

    mbist_burst_fifo #(.DW(BIST_DATA_WD), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_n   (rst_n),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .flush_i (f_flush),
        .din_i   (f_din),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        cs_d    = cs_q;
        sel_d   = sel_q;
        bl_d    = bl_q;
        beat_d  = beat_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_val_i && rdy_q) begin
                    we_d   = cmd_we_i;
                    adr_d  = cmd_adr_i;
                    cs_d   = cmd_cs_i;
                    sel_d  = cmd_sel_i;
                    bl_d   = cmd_bl_i;
                    beat_d = '0;
                    pcnt_d = '0;
                    if (cmd_bl_i == '0) begin
                        err_d = 1'b1;       // empty burst: consume and flag
                    end else begin
                        stb_d   = 1'b1;
                        state_d = cmd_we_i ? WR_BURST : RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (f_push)   pcnt_d = pcnt_q + BEAT_CNT_WD'(1);
                if (wb_ack_i) beat_d = beat_q + BEAT_CNT_WD'(1);
                if (wb_lack_i) begin
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                if (wb_ack_i) beat_d = beat_q + BEAT_CNT_WD'(1);
                if (wb_lack_i) begin
                    stb_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Finish in the cycle that hands out the last buffered beat.
                if (f_empty || (f_count == CNT_WD'(1) && f_pop)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            stb_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            cs_q    <= '0;
            sel_q   <= '0;
            bl_q    <= '0;
            beat_q  <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            cs_q    <= cs_d;
            sel_q   <= sel_d;
            bl_q    <= bl_d;
            beat_q  <= beat_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_rdy_o = rdy_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_cs_o   = cs_q;
    assign wb_sel_o  = sel_q;
    assign wb_bl_o   = bl_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mbist_burst_host.sv
module tb_mbist_burst_host;

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_val_i = 1'b0, cmd_rdy_o, cmd_we_i = 1'b0;
    logic [8:0]  cmd_adr_i = '0;
    logic [1:0]  cmd_cs_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [9:0]  cmd_bl_i = '0;
    logic        wdat_val_i = 1'b0, wdat_rdy_o;
    logic [31:0] wdat_i = '0;
    logic        rdat_val_o, rdat_rdy_i = 1'b0;
    logic [31:0] rdat_o;
    logic        wb_stb_o, wb_we_o, wb_bry_o;
    logic [8:0]  wb_adr_o;
    logic [1:0]  wb_cs_o;
    logic [3:0]  wb_sel_o;
    logic [9:0]  wb_bl_o;
    logic [31:0] wb_dat_o, wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_lack_i = 1'b0, wb_err_i = 1'b0;
    logic        done_o, err_o;

    int total = 0;
    int bad = 0;

    // Results of the last run_burst
    logic [31:0] r_cap [16];
    int r_ncap, r_done_cyc, r_err_cyc, r_lack_cyc, r_last_pop;
    int r_bry_bad, r_ack_empty, r_max_occ, r_hold_bad;
    logic r_bry_at_err, r_stb_after_err, r_rval_after_err, r_rdy_after_err;

    mbist_burst_host dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n),
        .cmd_val_i(cmd_val_i), .cmd_rdy_o(cmd_rdy_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_cs_i(cmd_cs_i), .cmd_sel_i(cmd_sel_i), .cmd_bl_i(cmd_bl_i),
        .wdat_val_i(wdat_val_i), .wdat_i(wdat_i), .wdat_rdy_o(wdat_rdy_o),
        .rdat_val_o(rdat_val_o), .rdat_o(rdat_o), .rdat_rdy_i(rdat_rdy_i),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_cs_o(wb_cs_o),
        .wb_sel_o(wb_sel_o), .wb_bl_o(wb_bl_o), .wb_dat_o(wb_dat_o), .wb_bry_o(wb_bry_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_lack_i(wb_lack_i), .wb_err_i(wb_err_i),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_val_i = 0; wdat_val_i = 0; rdat_rdy_i = 0;
        wb_ack_i = 0; wb_lack_i = 0; wb_err_i = 0;
    endtask

    // Issues one command and plays both the beat source/sink and the burst
    // slave: the slave acks one cycle after sampling wb_bry_o high and
    // raises lack with the last ack (or err in place of ack number err_at).
    task automatic run_burst(input bit we, input int bl, input logic [31:0] base,
                             input int gap_at, input int gap_len, input int rd_hold,
                             input int err_at, input int max_cyc);
        int wi, acks, pops, gap_left, occ;
        bit prev_bry, ended;
        wi = 0; acks = 0; pops = 0; gap_left = gap_len; prev_bry = 0; ended = 0;
        r_ncap = 0; r_done_cyc = -1; r_err_cyc = -1; r_lack_cyc = -1; r_last_pop = -1;
        r_bry_bad = 0; r_ack_empty = 0; r_max_occ = 0; r_hold_bad = 0;
        r_bry_at_err = 1; r_stb_after_err = 1; r_rval_after_err = 1; r_rdy_after_err = 0;
        cmd_val_i = 1; cmd_we_i = we; cmd_adr_i = 9'h010; cmd_cs_i = 2'd1;
        cmd_sel_i = 4'hF; cmd_bl_i = 10'(bl);
        tick();
        cmd_val_i = 0;
        for (int c = 0; c < max_cyc; c++) begin
            occ = we ? (wi - acks) : (acks - pops);
            wb_ack_i = 0; wb_lack_i = 0; wb_err_i = 0;
            if (prev_bry && !ended && acks < bl) begin
                if (acks == err_at) wb_err_i = 1;
                else begin
                    wb_ack_i  = 1;
                    wb_lack_i = (acks + 1 == bl);
                end
            end
            wb_dat_i   = base + 32'(acks);
            wdat_val_i = we && (wi < bl) && !(wi == gap_at && gap_left > 0);
            wdat_i     = base + 32'(wi);
            rdat_rdy_i = (c >= rd_hold);
            #1;
            if (!ended) begin
                if (!wb_stb_o || wb_we_o !== we || wb_adr_o !== 9'h010 ||
                    wb_cs_o !== 2'd1 || wb_bl_o !== 10'(bl)) r_hold_bad++;
                if (we && wb_bry_o !== ((occ - int'(wb_ack_i)) >= 1)) r_bry_bad++;
                if (!we && wb_bry_o && occ >= 3) r_bry_bad++;
            end
            if (we && wb_ack_i && occ == 0) r_ack_empty++;
            if (we && wb_ack_i && r_ncap < 16) begin r_cap[r_ncap] = wb_dat_o; r_ncap++; end
            if (!we && rdat_val_o && rdat_rdy_i && r_ncap < 16) begin
                r_cap[r_ncap] = rdat_o; r_ncap++; r_last_pop = c;
            end
            if (wb_err_i) r_bry_at_err = wb_bry_o;
            if (done_o && r_done_cyc < 0) r_done_cyc = c;
            if (err_o && r_err_cyc < 0) begin
                r_err_cyc = c; r_stb_after_err = wb_stb_o;
                r_rval_after_err = rdat_val_o; r_rdy_after_err = cmd_rdy_o;
            end
            if (wi == gap_at && gap_left > 0) gap_left--;
            if (wdat_val_i && wdat_rdy_o) wi++;
            if (wb_ack_i) acks++;
            if (!we && rdat_val_o && rdat_rdy_i) pops++;
            if (!we && (acks - pops) > r_max_occ) r_max_occ = acks - pops;
            if (wb_lack_i) begin ended = 1; r_lack_cyc = c; end
            if (wb_err_i) ended = 1;
            prev_bry = wb_bry_o;
            if (r_done_cyc >= 0 || r_err_cyc >= 0) break;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick(); tick();
        total++;
        if ({cmd_rdy_o, wdat_rdy_o, rdat_val_o, rdat_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cs_o,
             wb_sel_o, wb_bl_o, wb_dat_o, wb_bry_o, done_o, err_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: stb=%b rdy=%b bry=%b done=%b err=%b need all 0",
                            wb_stb_o, cmd_rdy_o, wb_bry_o, done_o, err_o);
        end
        rst_n = 1;
        tick();
        total++;
        if (cmd_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_cmd_rdy: got %b need 1", cmd_rdy_o); end
    endtask

    task automatic test_write_burst();
        logic [31:0] exp;
        run_burst(1, 4, 32'hA0, -1, 0, 0, -1, 60);
        total++;
        if (r_ncap !== 4) begin bad++; $display("FAIL wr_ack_count: got %0d need 4", r_ncap); end
        for (int i = 0; i < 4; i++) begin
            exp = 32'hA0 + 32'(i);
            total++;
            if (r_cap[i] !== exp) begin bad++; $display("FAIL wr_beat%0d: got %h need %h", i, r_cap[i], exp); end
        end
        total++;
        if (r_lack_cyc < 0 || r_done_cyc !== r_lack_cyc + 1) begin
            bad++; $display("FAIL wr_done_timing: done at %0d need lack+1 (lack %0d)", r_done_cyc, r_lack_cyc);
        end
        total++;
        if (r_bry_bad !== 0) begin bad++; $display("FAIL wr_bry: %0d bad cycles need 0", r_bry_bad); end
        total++;
        if (r_hold_bad !== 0) begin bad++; $display("FAIL wr_fields_hold: %0d bad cycles need 0", r_hold_bad); end
    endtask

    task automatic test_read_burst();
        logic [31:0] exp;
        run_burst(0, 6, 32'hB0, -1, 0, 12, -1, 80);
        total++;
        if (r_ncap !== 6) begin bad++; $display("FAIL rd_beat_count: got %0d need 6", r_ncap); end
        for (int i = 0; i < 6; i++) begin
            exp = 32'hB0 + 32'(i);
            total++;
            if (r_cap[i] !== exp) begin bad++; $display("FAIL rd_beat%0d: got %h need %h", i, r_cap[i], exp); end
        end
        total++;
        if (r_max_occ !== 4) begin bad++; $display("FAIL rd_max_occupancy: got %0d need 4", r_max_occ); end
        total++;
        if (r_bry_bad !== 0) begin bad++; $display("FAIL rd_bry_at_3: %0d bad cycles need 0", r_bry_bad); end
        total++;
        if (r_last_pop < 0 || r_done_cyc !== r_last_pop + 1) begin
            bad++; $display("FAIL rd_done_timing: done at %0d need last_pop+1 (last pop %0d)", r_done_cyc, r_last_pop);
        end
    endtask

    task automatic test_write_underrun();
        logic [31:0] exp;
        run_burst(1, 3, 32'hC0, 2, 5, 0, -1, 60);
        total++;
        if (r_ncap !== 3) begin bad++; $display("FAIL un_ack_count: got %0d need 3", r_ncap); end
        for (int i = 0; i < 3; i++) begin
            exp = 32'hC0 + 32'(i);
            total++;
            if (r_cap[i] !== exp) begin bad++; $display("FAIL un_beat%0d: got %h need %h", i, r_cap[i], exp); end
        end
        total++;
        if (r_bry_bad !== 0) begin bad++; $display("FAIL un_bry: %0d bad cycles need 0", r_bry_bad); end
        total++;
        if (r_ack_empty !== 0) begin bad++; $display("FAIL un_ack_in_gap: %0d acks with no data need 0", r_ack_empty); end
        total++;
        if (r_done_cyc !== r_lack_cyc + 1) begin bad++; $display("FAIL un_done: got %0d need %0d", r_done_cyc, r_lack_cyc + 1); end
    endtask

    task automatic test_read_error();
        run_burst(0, 5, 32'hD0, -1, 0, 100, 2, 60);
        total++;
        if (r_err_cyc !== 4) begin bad++; $display("FAIL er_err_pulse: at cycle %0d need 4", r_err_cyc); end
        total++;
        if (r_bry_at_err !== 1'b0) begin bad++; $display("FAIL er_bry_drop: got %b need 0", r_bry_at_err); end
        total++;
        if (r_stb_after_err !== 1'b0) begin bad++; $display("FAIL er_stb_drop: got %b need 0", r_stb_after_err); end
        total++;
        if (r_rval_after_err !== 1'b0) begin bad++; $display("FAIL er_fifo_flush: rdat_val %b need 0", r_rval_after_err); end
        total++;
        if (r_rdy_after_err !== 1'b1) begin bad++; $display("FAIL er_idle: cmd_rdy %b need 1", r_rdy_after_err); end
        total++;
        if (r_done_cyc !== -1) begin bad++; $display("FAIL er_no_done: done at %0d need none", r_done_cyc); end
    endtask

    task automatic test_bl_zero();
        cmd_val_i = 1; cmd_we_i = 1; cmd_adr_i = 9'h020; cmd_bl_i = 10'd0;
        total++;
        if (cmd_rdy_o !== 1'b1) begin bad++; $display("FAIL bl0_rdy: got %b need 1", cmd_rdy_o); end
        tick();
        cmd_val_i = 0;
        total++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL bl0_err: got %b need 1", err_o); end
        total++;
        if (wb_stb_o !== 1'b0) begin bad++; $display("FAIL bl0_stb: got %b need 0", wb_stb_o); end
        tick();
        total++;
        if ({err_o, wb_stb_o, cmd_rdy_o} !== 3'b001) begin
            bad++; $display("FAIL bl0_after: err/stb/rdy %b%b%b need 001", err_o, wb_stb_o, cmd_rdy_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        cmd_val_i = 1; cmd_we_i = 1; cmd_adr_i = 9'h010; cmd_cs_i = 2'd1; cmd_bl_i = 10'd4;
        tick();
        cmd_val_i = 0; wdat_val_i = 1; wdat_i = 32'hA0;
        tick();
        wdat_i = 32'hA1;
        tick();
        wdat_val_i = 0;
        rst_n = 0;
        #1;
        total++;
        if ({cmd_rdy_o, wdat_rdy_o, rdat_val_o, rdat_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cs_o,
             wb_sel_o, wb_bl_o, wb_dat_o, wb_bry_o, done_o, err_o} !== '0) begin
            bad++; $display("FAIL midrst_outputs: stb=%b dat=%h bry=%b need all 0", wb_stb_o, wb_dat_o, wb_bry_o);
        end
        tick();
        rst_n = 1;
        tick();
        total++;
        if (cmd_rdy_o !== 1'b1) begin bad++; $display("FAIL midrst_rdy: got %b need 1", cmd_rdy_o); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_o || err_o) pulses++;
            tick();
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL midrst_pulse: %0d done/err pulses need 0", pulses); end
        run_burst(1, 2, 32'h50, -1, 0, 0, -1, 40);
        total++;
        if (r_ncap !== 2 || r_cap[0] !== 32'h50 || r_cap[1] !== 32'h51) begin
            bad++; $display("FAIL midrst_discard: first beats %h %h need 00000050 00000051", r_cap[0], r_cap[1]);
        end
    endtask

`ifdef MBIST_BURST_TIMEOUT_EN
    task automatic test_timeout();
        int ec;
        ec = -1;
        cmd_val_i = 1; cmd_we_i = 0; cmd_adr_i = 9'h010; cmd_bl_i = 10'd4;
        tick();
        cmd_val_i = 0;
        for (int c = 0; c < 400; c++) begin
            if (err_o) begin ec = c; break; end
            tick();
        end
        total++;
        if (ec !== 256) begin bad++; $display("FAIL timeout_err: err at %0d need 256", ec); end
        total++;
        if (wb_stb_o !== 1'b0) begin bad++; $display("FAIL timeout_stb: got %b need 0", wb_stb_o); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_write_underrun();
        test_read_error();
        test_bl_zero();
        test_reset_mid_burst();
`ifdef MBIST_BURST_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbist_burst_host.md
MBIST_BURST_HOST -- requirements
Module: mbist_burst_host

Interface
REQ-001 SHALL have parameter BIST_NO_SRAM, default 4: SRAM count; CS_WD = (BIST_NO_SRAM+1)/2.
REQ-002 SHALL have parameter BIST_ADDR_WD, default 9: word-address width.
REQ-003 SHALL have parameter BIST_DATA_WD, default 32: data width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: beat buffer depth, power of two, minimum 2.
REQ-005 wb_clk_i  in  1  the only clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_val_i / cmd_rdy_o  in/out  1/1  command handshake.
REQ-008 cmd_we_i, cmd_adr_i, cmd_cs_i, cmd_sel_i, cmd_bl_i  in  1/BIST_ADDR_WD/CS_WD/BIST_DATA_WD/8/10  command fields.
REQ-009 wdat_val_i, wdat_i / wdat_rdy_o  in/out  1, BIST_DATA_WD / 1  write-beat stream.
REQ-010 rdat_val_o, rdat_o / rdat_rdy_i  out/in  1, BIST_DATA_WD / 1  read-beat stream.
REQ-011 wb_stb_o, wb_we_o, wb_adr_o, wb_cs_o, wb_sel_o, wb_bl_o, wb_dat_o, wb_bry_o  out  burst port to the mbist_wb stage.
REQ-012 wb_dat_i, wb_ack_i, wb_lack_i, wb_err_i  in  BIST_DATA_WD/1/1/1  burst responses.
REQ-013 done_o, err_o  out  1/1  one-cycle pulses: burst completed / burst aborted.

Function
REQ-014 FSM states SHALL be IDLE, WR_BURST, RD_BURST and DRAIN.
REQ-015 IDLE: cmd_rdy_o=1; on cmd_val_i the fields SHALL be latched into wb_*_o, wb_stb_o=1 from the next cycle, next state WR_BURST or RD_BURST from cmd_we_i.
REQ-016 A command with cmd_bl_i=0 SHALL be accepted, SHALL NOT raise wb_stb_o, and SHALL pulse err_o one cycle later.
REQ-017 wb_stb_o, wb_we_o, wb_adr_o, wb_cs_o, wb_sel_o and wb_bl_o SHALL hold steady from acceptance until wb_lack_i or abort.
REQ-018 Beat buffer: one FIFO_DEPTH-entry FIFO shared by both directions; count width log2(FIFO_DEPTH)+1.
REQ-019 WR_BURST: wdat_rdy_o = not full and pushed count < bl; the FIFO SHALL pop on wb_ack_i; wb_dat_o = FIFO head.
REQ-020 WR_BURST: wb_bry_o = ((count - wb_ack_i) >= 1), combinational, so the head is valid the cycle after each bry sample.
REQ-021 RD_BURST: the FIFO SHALL push wb_dat_i on wb_ack_i; rdat_val_o = not empty; the FIFO SHALL pop on rdat_val_o and rdat_rdy_i.
REQ-022 RD_BURST: wb_bry_o = (free entries >= 2); the one outstanding ack SHALL never overflow the FIFO.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; a full push-with-pop SHALL be legal.
REQ-024 A 10-bit beat counter SHALL increment per wb_ack_i; wb_lack_i SHALL end the burst.
REQ-025 On wb_lack_i: write goes to IDLE with done_o; read goes to DRAIN until the FIFO is empty, then done_o and IDLE.
REQ-026 wb_err_i in any non-IDLE state SHALL drop wb_stb_o and wb_bry_o, flush the FIFO, pulse err_o and return to IDLE next cycle.
REQ-027 wb_ack_i or wb_lack_i arriving in IDLE SHALL be ignored.

Reset
REQ-028 Asserting rst_n SHALL force IDLE, an empty FIFO and a zero counter; every output SHALL be 0 except cmd_rdy_o = 1 once rst_n is deasserted.
REQ-029 Reset mid-burst SHALL discard all buffered beats with no done_o or err_o pulse.

Configuration
REQ-030 With MBIST_BURST_TIMEOUT_EN defined, an 8-bit watchdog SHALL clear on each ack and count in WR_BURST/RD_BURST; at 255 it SHALL abort exactly as in REQ-026.
REQ-031 Without MBIST_BURST_TIMEOUT_EN, no watchdog logic SHALL exist and a stalled burst SHALL wait indefinitely.

Structure
REQ-032 The FSM state enum and the FIFO_DEPTH default SHALL live in shared package mbist_pkg.
REQ-033 The FIFO SHALL be sub-module mbist_burst_fifo, with ports push/pop/flush/full/empty/count.

Verification
REQ-034 Write burst: bl=4, adr=0x010, cs=1, four write beats 0xA0..A3 back-to-back -> four acks, beats leave in order, done_o one cycle after lack.
REQ-035 Read burst, bl=6, rdat_rdy_i held low -> wb_bry_o drops at 3 entries, no overflow; release -> six beats in order, done_o after the last pop.
REQ-036 Write underrun, bl=3, beat 2 delayed 5 cycles -> wb_bry_o low during the gap, no ack in the gap, data intact.
REQ-037 wb_err_i on read beat 2 of 5 -> wb_stb_o low next cycle, FIFO empty, err_o pulsed, state IDLE.
REQ-038 bl=0 -> no wb_stb_o, err_o pulse; rst_n low mid-burst -> all outputs 0, then cmd_rdy_o=1.
REQ-039 With MBIST_BURST_TIMEOUT_EN: wb_ack_i held low for 255 cycles -> abort with err_o.
